// File: rtl/silc_pkg.sv
// -----------------------------------------------------------------------------
// silc_pkg
// Shared types and constants for the SILC measurement engine.
//   mode_e  : CPU-selected operating mode (STOP / FAST / SLOW / invalid)
//   err_e   : ErrorCode values presented alongside SILCReading
//   state_e : measurement FSM states
//   HIGH_THRESH / LOW_THRESH : default ADC slope thresholds
// -----------------------------------------------------------------------------
package silc_pkg;

    typedef enum logic [1:0] {
        MODE_STOP = 2'd0,
        MODE_FAST = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_BAD  = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_TIMEOUT     = 3'd1,
        ERR_OVERFLOW    = 3'd2,
        ERR_ZERO_SLOPES = 3'd3,
        ERR_BAD_MODE    = 3'd4,
        ERR_NO_DATA     = 3'd5
    } err_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_WAIT_FALL,
        ST_COUNT,
        ST_DONE
    } state_e;

    // ADC >= HIGH_THRESH arms a slope; ADC < LOW_THRESH ends it.
    localparam logic [11:0] HIGH_THRESH = 12'hC00;
    localparam logic [11:0] LOW_THRESH  = 12'h100;

endpackage

// File: rtl/silc_if.sv
// -----------------------------------------------------------------------------
// silc_if
// CPU / ADC side bundle of the SILC engine.
//   Mode, Enable, NumDescendingSlopes, TimeoutThreshold : configuration from CPU
//   ADCReading                                          : ADC sample every clock
//   CPUReadComplete                                     : CPU consumed the result
//   SILCReading, ErrorCode, SILCValReady                : result presented to CPU
// modport master: the CPU/ADC side; modport slave: the SILC engine.
// -----------------------------------------------------------------------------
interface silc_if;

    logic [1:0]  Mode;
    logic        Enable;
    logic [11:0] ADCReading;
    logic [5:0]  NumDescendingSlopes;
    logic [11:0] TimeoutThreshold;
    logic        CPUReadComplete;
    logic [15:0] SILCReading;
    logic [2:0]  ErrorCode;
    logic        SILCValReady;

    modport master (
        output Mode, Enable, ADCReading, NumDescendingSlopes, TimeoutThreshold,
               CPUReadComplete,
        input  SILCReading, ErrorCode, SILCValReady
    );

    modport slave (
        input  Mode, Enable, ADCReading, NumDescendingSlopes, TimeoutThreshold,
               CPUReadComplete,
        output SILCReading, ErrorCode, SILCValReady
    );

endinterface

// File: rtl/silc_slope_timer.sv
// -----------------------------------------------------------------------------
// silc_slope_timer
// Phase counter with timeout compare.
//   Clk, Reset   : system clock, synchronous active-high reset
//   i_clear      : restart the count (asserted on every phase entry)
//   i_enable     : count this cycle (saturates at all-ones)
//   i_threshold  : timeout limit in cycles, 0 disables the timeout
//   o_count      : cycles already spent in the current phase (0 on first cycle)
//   o_timeout    : the current cycle is the i_threshold-th cycle of the phase
// -----------------------------------------------------------------------------
module silc_slope_timer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [11:0] i_threshold,
    output logic [15:0] o_count,
    output logic        o_timeout
);

    logic [15:0] r_count;

    // NOTE: sequential state is written only with non-blocking (<=) assignments
    // so every register samples the pre-edge values of its neighbours.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != 16'hFFFF)) begin
            r_count <= r_count + 16'd1;
        end
    end

    assign o_count   = r_count;
    // Widened compare so the +1 cannot wrap at the saturated count.
    assign o_timeout = (i_threshold != 12'd0) &&
                       (({1'b0, r_count} + 17'd1) >= {5'd0, i_threshold});

endmodule

// File: rtl/silc.sv
// -----------------------------------------------------------------------------
// silc
// Stress-induced leakage current measurement engine. Times successive
// descending ADC slopes in clock cycles, accumulates NumDescendingSlopes of
// them into a saturating 16-bit result and hands it to the CPU with a
// ready / read-complete handshake.
//   Clk, Reset : system clock, synchronous active-high reset
//   bus        : silc_if.slave (configuration, ADC sample, result handshake)
// -----------------------------------------------------------------------------
module silc
    import silc_pkg::*;
(
    input  logic  Clk,
    input  logic  Reset,
    silc_if.slave bus
);

    state_e      r_state, w_next_state;
    logic [15:0] r_acc;
    logic        r_ovf;
    logic [5:0]  r_slope_idx;
    logic [5:0]  r_num_slopes;
    logic [11:0] r_timeout_thr;
    logic [15:0] r_last_good;
    logic        r_have_good;
    logic [15:0] r_reading;
    err_e        r_err;
    logic        r_ready;

    mode_e       w_mode;
    logic        w_run, w_slow_run, w_measuring, w_phase_change;
    logic        w_slope_end, w_last_slope, w_timeout;
    logic [15:0] w_count, w_slope_len, w_acc_sat;
    logic [16:0] w_acc_sum;
    logic        w_ovf_next;
    logic        w_done_load, w_good_load;
    err_e        w_done_err;
    logic [15:0] w_done_value;

    assign w_mode      = mode_e'(bus.Mode);
    assign w_run       = bus.Enable && (w_mode != MODE_STOP);
    assign w_slow_run  = bus.Enable && (w_mode == MODE_SLOW);
    assign w_measuring = (r_state == ST_ARM) || (r_state == ST_WAIT_FALL) ||
                         (r_state == ST_COUNT);
    assign w_phase_change = (w_next_state != r_state);

    // The phase counter restarts on COUNT entry, so the slope length
    // (first falling sample counted as 1) is the phase count plus one.
    assign w_slope_len  = (w_count == 16'hFFFF) ? w_count : w_count + 16'd1;
    assign w_acc_sum    = {1'b0, r_acc} + {1'b0, w_slope_len};
    assign w_acc_sat    = w_acc_sum[16] ? 16'hFFFF : w_acc_sum[15:0];
    assign w_ovf_next   = r_ovf | w_acc_sum[16];
    assign w_slope_end  = (bus.ADCReading < LOW_THRESH);
    assign w_last_slope = ((r_slope_idx + 6'd1) == r_num_slopes);

    silc_slope_timer u_timer (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_clear     (w_phase_change),
        .i_enable    (w_measuring),
        .i_threshold (r_timeout_thr),
        .o_count     (w_count),
        .o_timeout   (w_timeout)
    );

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_done_load  = 1'b0;
        w_good_load  = 1'b0;
        w_done_err   = ERR_NONE;
        w_done_value = r_last_good;
        case (r_state)
            ST_IDLE: begin
                if (bus.Enable) begin
                    case (w_mode)
                        MODE_SLOW: begin
                            if (bus.NumDescendingSlopes == 6'd0) begin
                                w_next_state = ST_DONE;
                                w_done_load  = 1'b1;
                                w_done_err   = ERR_ZERO_SLOPES;
                                w_done_value = r_reading;
                            end else begin
                                w_next_state = ST_ARM;
                            end
                        end
                        MODE_FAST: begin
                            w_next_state = ST_DONE;
                            w_done_load  = 1'b1;
                            w_done_err   = r_have_good ? ERR_NONE : ERR_NO_DATA;
                        end
                        MODE_BAD: begin
                            w_next_state = ST_DONE;
                            w_done_load  = 1'b1;
                            w_done_err   = ERR_BAD_MODE;
                            w_done_value = r_reading;
                        end
                        default: ;
                    endcase
                end
            end
            ST_ARM: begin
                if (!w_slow_run) begin
                    w_next_state = ST_IDLE;
                end else if (bus.ADCReading >= HIGH_THRESH) begin
                    w_next_state = ST_WAIT_FALL;
                end else if (w_timeout) begin
                    w_next_state = ST_DONE;
                    w_done_load  = 1'b1;
                    w_done_err   = ERR_TIMEOUT;
                end
            end
            ST_WAIT_FALL: begin
                if (!w_slow_run) begin
                    w_next_state = ST_IDLE;
                end else if (bus.ADCReading < HIGH_THRESH) begin
                    w_next_state = ST_COUNT;
                end else if (w_timeout) begin
                    w_next_state = ST_DONE;
                    w_done_load  = 1'b1;
                    w_done_err   = ERR_TIMEOUT;
                end
            end
            ST_COUNT: begin
                // Slope end is tested before timeout: a coincident end wins.
                if (!w_slow_run) begin
                    w_next_state = ST_IDLE;
                end else if (w_slope_end) begin
                    if (w_last_slope) begin
                        w_next_state = ST_DONE;
                        w_done_load  = 1'b1;
                        w_done_value = w_acc_sat;
                        w_done_err   = w_ovf_next ? ERR_OVERFLOW : ERR_NONE;
                        w_good_load  = !w_ovf_next;
                    end else begin
                        w_next_state = ST_ARM;
                    end
                end else if (w_timeout) begin
                    w_next_state = ST_DONE;
                    w_done_load  = 1'b1;
                    w_done_err   = ERR_TIMEOUT;
                end
            end
            ST_DONE: begin
                if (!w_run || (r_ready && bus.CPUReadComplete)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state       <= ST_IDLE;
            r_acc         <= '0;
            r_ovf         <= 1'b0;
            r_slope_idx   <= '0;
            r_num_slopes  <= '0;
            r_timeout_thr <= '0;
            r_last_good   <= '0;
            r_have_good   <= 1'b0;
            r_reading     <= '0;
            r_err         <= ERR_NONE;
            r_ready       <= 1'b0;
        end else begin
            r_state <= w_next_state;
            // Ready rises one cycle after DONE entry and drops as DONE is left.
            r_ready <= (r_state == ST_DONE) && (w_next_state == ST_DONE);
            if ((r_state == ST_IDLE) && (w_next_state == ST_ARM)) begin
                r_acc         <= '0;
                r_ovf         <= 1'b0;
                r_slope_idx   <= '0;
                r_num_slopes  <= bus.NumDescendingSlopes;
                r_timeout_thr <= bus.TimeoutThreshold;
                r_err         <= ERR_NONE;
            end
            if ((r_state == ST_COUNT) && w_slow_run && w_slope_end) begin
                r_acc       <= w_acc_sat;
                r_ovf       <= w_ovf_next;
                r_slope_idx <= r_slope_idx + 6'd1;
            end
            if (w_done_load) begin
                r_reading <= w_done_value;
                r_err     <= w_done_err;
            end
            if (w_good_load) begin
                r_last_good <= w_acc_sat;
                r_have_good <= 1'b1;
            end
        end
    end

    assign bus.SILCReading  = r_reading;
    assign bus.ErrorCode    = r_err;
    assign bus.SILCValReady = r_ready;

endmodule

// File: tb/tb_silc.sv
// -----------------------------------------------------------------------------
// tb_silc
// Directed self-checking bench for silc. Inputs change 1 ns after each rising
// edge and outputs are observed at the same point, so every observation
// reflects the registers updated by the preceding edge.
// -----------------------------------------------------------------------------
module tb_silc;
    import silc_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc;
    logic [11:0] pat [6];

    silc_if bus ();

    silc dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int max_cyc, output int cycles);
        cycles = 0;
        while ((bus.SILCValReady !== 1'b1) && (cycles < max_cyc)) begin
            tick();
            cycles++;
        end
        check({tag, " ready"}, 32'(bus.SILCValReady), 32'd1);
    endtask

    task automatic go_stop();
        bus.Mode = MODE_STOP;
        tick();
        tick();
    endtask

    initial begin
        pat[0] = 12'hFFF; pat[1] = 12'hFBF; pat[2] = 12'h87F;
        pat[3] = 12'h7FF; pat[4] = 12'h07F; pat[5] = 12'h000;
        bus.Mode = MODE_STOP;
        bus.Enable = 1'b0;
        bus.ADCReading = 12'h000;
        bus.NumDescendingSlopes = 6'd0;
        bus.TimeoutThreshold = 12'd0;
        bus.CPUReadComplete = 1'b0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst reading", 32'(bus.SILCReading), 32'h0);
        check("rst code", 32'(bus.ErrorCode), 32'h0);
        check("rst ready", 32'(bus.SILCValReady), 32'h0);

        // 1: two slopes of 2 cycles each -> 4
        bus.Enable = 1'b1;
        bus.NumDescendingSlopes = 6'd2;
        bus.TimeoutThreshold = 12'd30;
        bus.CPUReadComplete = 1'b1;
        bus.Mode = MODE_SLOW;
        cyc = 0;
        while ((bus.SILCValReady !== 1'b1) && (cyc < 200)) begin
            bus.ADCReading = pat[cyc % 6];
            tick();
            cyc++;
        end
        check("t1 ready", 32'(bus.SILCValReady), 32'h1);
        check("t1 reading", 32'(bus.SILCReading), 32'd4);
        check("t1 code", 32'(bus.ErrorCode), 32'(ERR_NONE));
        tick();
        check("t1 pulse", 32'(bus.SILCValReady), 32'h0);

        // 2: STOP holds result with ready low; FAST re-presents LastGood
        bus.Mode = MODE_STOP;
        tick(); tick(); tick(); tick();
        check("t2 stop ready", 32'(bus.SILCValReady), 32'h0);
        check("t2 stop reading", 32'(bus.SILCReading), 32'd4);
        bus.Mode = MODE_FAST;
        wait_ready("t2 fast", 10, cyc);
        check("t2 fast latency", 32'(cyc), 32'd2);
        check("t2 fast reading", 32'(bus.SILCReading), 32'd4);
        check("t2 fast code", 32'(bus.ErrorCode), 32'(ERR_NONE));
        go_stop();

        // 3: ADC never arms, TO=30 -> timeout with LastGood
        bus.ADCReading = 12'h000;
        bus.NumDescendingSlopes = 6'd1;
        bus.TimeoutThreshold = 12'd30;
        bus.Mode = MODE_SLOW;
        wait_ready("t3", 100, cyc);
        // 1 edge into ARM, 30 cycles in ARM, then ready one edge after DONE
        check("t3 latency", 32'(cyc), 32'd32);
        check("t3 code", 32'(bus.ErrorCode), 32'(ERR_TIMEOUT));
        check("t3 reading", 32'(bus.SILCReading), 32'd4);
        go_stop();

        // 4: 87F held 5 cycles -> slope of 5; no read-complete keeps ready high
        bus.CPUReadComplete = 1'b0;
        bus.ADCReading = 12'h000;
        bus.Mode = MODE_SLOW;
        tick();
        bus.ADCReading = 12'hFFF;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.ADCReading = 12'h87F;
            tick();
        end
        bus.ADCReading = 12'h07F;
        tick();
        bus.ADCReading = 12'h000;
        tick();
        check("t4 ready", 32'(bus.SILCValReady), 32'h1);
        check("t4 reading", 32'(bus.SILCReading), 32'd5);
        check("t4 code", 32'(bus.ErrorCode), 32'(ERR_NONE));
        for (int i = 0; i < 4; i++) begin
            bus.ADCReading = pat[i];
            tick();
            check("t4 hold ready", 32'(bus.SILCValReady), 32'h1);
            check("t4 hold reading", 32'(bus.SILCReading), 32'd5);
        end
        bus.CPUReadComplete = 1'b1;
        tick();
        check("t4 release", 32'(bus.SILCValReady), 32'h0);
        go_stop();

        // Slope end on the timeout cycle: TO=2, slope of 2 still completes
        bus.TimeoutThreshold = 12'd2;
        bus.ADCReading = 12'h000;
        bus.Mode = MODE_SLOW;
        tick();
        bus.ADCReading = 12'hFFF; tick();
        bus.ADCReading = 12'h87F; tick();
        bus.ADCReading = 12'h7FF; tick();
        bus.ADCReading = 12'h07F; tick();
        bus.ADCReading = 12'h000; tick();
        check("tie ready", 32'(bus.SILCValReady), 32'h1);
        check("tie reading", 32'(bus.SILCReading), 32'd2);
        check("tie code", 32'(bus.ErrorCode), 32'(ERR_NONE));
        go_stop();

        // 6: reset while counting
        bus.CPUReadComplete = 1'b0;
        bus.TimeoutThreshold = 12'd0;
        bus.Mode = MODE_SLOW;
        tick();
        bus.ADCReading = 12'hFFF; tick();
        bus.ADCReading = 12'h87F; tick();
        tick();
        check("t6 pre state", 32'(dut.r_state), 32'(ST_COUNT));
        check("t6 pre reading", 32'(bus.SILCReading), 32'd2);
        rst = 1'b1;
        bus.Mode = MODE_STOP;
        tick();
        check("t6 reading", 32'(bus.SILCReading), 32'h0);
        check("t6 code", 32'(bus.ErrorCode), 32'h0);
        check("t6 ready", 32'(bus.SILCValReady), 32'h0);
        check("t6 state", 32'(dut.r_state), 32'(ST_IDLE));
        rst = 1'b0;
        tick();

        // 5: error codes
        bus.CPUReadComplete = 1'b1;
        bus.Mode = MODE_FAST;
        wait_ready("t5 nodata", 10, cyc);
        check("t5 nodata code", 32'(bus.ErrorCode), 32'(ERR_NO_DATA));
        check("t5 nodata reading", 32'(bus.SILCReading), 32'h0);
        go_stop();
        bus.Mode = MODE_BAD;
        wait_ready("t5 badmode", 10, cyc);
        check("t5 badmode code", 32'(bus.ErrorCode), 32'(ERR_BAD_MODE));
        go_stop();
        bus.NumDescendingSlopes = 6'd0;
        bus.Mode = MODE_SLOW;
        wait_ready("t5 zero", 10, cyc);
        check("t5 zero code", 32'(bus.ErrorCode), 32'(ERR_ZERO_SLOPES));
        go_stop();

        // ErrorCode clears as a new measurement starts
        bus.NumDescendingSlopes = 6'd1;
        bus.ADCReading = 12'h000;
        bus.Mode = MODE_SLOW;
        tick();
        check("clr code", 32'(bus.ErrorCode), 32'(ERR_NONE));
        check("clr ready", 32'(bus.SILCValReady), 32'h0);
        go_stop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
